rr_arbiter_4req: RTL
====================

// Module: rr_arbiter_4req
// PURPOSE
//  Round-robin arbiter sharing one 4-input encoder/datapath slot among 4 requesters.
//  Issues a registered one-hot grant plus its 2-bit encoded index (4-to-2 encoding).
//  Grant is held while the owner keeps requesting, bounded by a max-hold timeout.
//  Sits between requesting sub-blocks and the shared encoder/datapath.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles per owner; 0 = unlimited; legal 0..255
// PORTS
//  clk        in   1  single clock, all logic on rising edge
//  rst        in   1  synchronous reset, active-high
//  req        in   4  request vector, bit i = requester i
//  gnt        out  4  one-hot grant (registered), 0000 when none
//  gnt_idx    out  2  encoded index of gnt bit; 00 when gnt=0000
//  gnt_valid  out  1  |gnt
// BEHAVIOUR
//  - Reset (rst=1 at edge): gnt=0000, gnt_idx=00, gnt_valid=0, ptr=0, hold_cnt=0, state=IDLE.
//    rst mid-grant: grant drops at that edge, no completion.
//  - State: IDLE (no owner), BUSY (owner = gnt_idx).
//  - Winner search: first set bit of the candidate vector scanning ptr, ptr+1, .. mod 4.
//  - IDLE: req!=0 at edge t -> gnt = winner at edge t (visible cycle t+1, 1-cycle latency).
//    ptr <= winner+1 mod 4; hold_cnt <= 1; state <= BUSY. req=0 -> stay IDLE.
//  - BUSY, per edge:
//    a) req[owner]=1, timeout not reached: hold grant, hold_cnt++.
//    b) req[owner]=0 (release): re-arbitrate over req with owner excluded.
//       Other req -> new grant at the same edge, no idle bubble.
//       None -> gnt=0000, state IDLE.
//    c) timeout (MAX_HOLD!=0, hold_cnt==MAX_HOLD, req[owner]=1): re-arbitrate excluding owner.
//       Other req -> switch. None -> owner keeps grant, hold_cnt <= 1.
//  - Every new grant (incl. switch): ptr <= winner+1 mod 4, hold_cnt <= 1.
//  - Regrant after timeout-with-no-competitor leaves ptr unchanged.
//  - gnt is always one-hot or zero; gnt_idx/gnt_valid derived from the registered gnt.
//  - hold_cnt 8 bits, saturates at 255 when MAX_HOLD=0.
//  - Requests arriving for non-owners never preempt before release/timeout.
//  - A requester that drops req without a grant is simply not considered.
// TESTING
//  1 rst=1 two cycles, req=1111 -> gnt=0000, gnt_idx=00, gnt_valid=0 throughout.
//  2 req=0001 from cycle 0 -> gnt=0001/idx 00/valid 1 from cycle 1.
//    req->0000 -> gnt=0000 one cycle later.
//  3 MAX_HOLD=4, req=1111 held -> grants 0001,0010,0100,1000,0001, each exactly 4 cycles.
//  4 After reset, req=0110 -> gnt=0010. Drop req[1] -> next cycle gnt=0100, no 0000 cycle.
//  5 MAX_HOLD=4, only req=1000 held 12 cycles -> gnt=1000 continuous, never 0000.
//  6 Grant to 0100 active, pulse rst 1 cycle with req=1111 -> gnt=0000.
//    Then gnt=0001 one cycle after rst falls (ptr back to 0).

Source files
------------

// File: rtl/rr_arbiter_4req_if.sv
// rtl/rr_arbiter_4req_if.sv - request/grant bundle between requesters and the round-robin arbiter
//
// Purpose: carries the 4-bit request vector toward the arbiter and the
//          registered grant (one-hot, encoded index, valid) back out.
// Signals:
//   req        4  request vector, bit i = requester i
//   gnt        4  one-hot grant, 0000 when none
//   gnt_idx    2  encoded index of the granted bit, 00 when none
//   gnt_valid  1  high whenever gnt is non-zero
// Modports:
//   master  requester side (drives req, observes the grant)
//   slave   arbiter side (observes req, drives the grant)
interface rr_arbiter_4req_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );
endinterface

// File: rtl/rr_arbiter_4req.sv
// rtl/rr_arbiter_4req.sv - 4-requester round-robin arbiter with bounded grant hold
//
// Purpose: shares one encoder/datapath slot among 4 requesters. A grant is
//          held while its owner keeps requesting, up to MAX_HOLD consecutive
//          cycles, then passed on round-robin if anyone else is waiting.
// Parameters:
//   MAX_HOLD  max consecutive grant cycles per owner, 0 = unlimited (0..255)
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  synchronous reset, active-high
//   bus   slave modport of rr_arbiter_4req_if (req in; gnt, gnt_idx, gnt_valid out)
module rr_arbiter_4req #(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_arbiter_4req_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [7:0]  hold_cnt;
  logic [3:0]  gnt_r;
  logic [1:0]  gnt_idx_r;
  logic        gnt_valid_r;

  logic [3:0]  cand;
  logic [2:0]  win;
  logic        owner_req;
  logic        timeout;

  // Returns {found, index} of the first set bit of c scanning base, base+1, ... mod 4.
  // Scanning from the far end lets the nearest offset overwrite the result last.
  function automatic logic [2:0] pick(input logic [3:0] c, input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] i;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      i = base + 2'(k);
      if (c[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  always_comb begin
    // Owner is excluded from competition; in IDLE gnt is zero so this is plain req.
    cand      = bus.req & ~gnt_r;
    win       = pick(cand, ptr);
    owner_req = |(bus.req & gnt_r);
    timeout   = (MAX_HOLD != 0) && (hold_cnt == 8'(MAX_HOLD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= 8'd0;
      gnt_r       <= 4'b0000;
      gnt_idx_r   <= 2'd0;
      gnt_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win[2]) begin
            state       <= BUSY;
            gnt_r       <= 4'b0001 << win[1:0];
            gnt_idx_r   <= win[1:0];
            gnt_valid_r <= 1'b1;
            ptr         <= win[1:0] + 2'd1;
            hold_cnt    <= 8'd1;
          end
        end
        BUSY: begin
          if (!owner_req || timeout) begin
            if (win[2]) begin
              // Hand over in the same edge: no idle bubble between owners.
              gnt_r       <= 4'b0001 << win[1:0];
              gnt_idx_r   <= win[1:0];
              gnt_valid_r <= 1'b1;
              ptr         <= win[1:0] + 2'd1;
              hold_cnt    <= 8'd1;
            end else if (!owner_req) begin
              state       <= IDLE;
              gnt_r       <= 4'b0000;
              gnt_idx_r   <= 2'd0;
              gnt_valid_r <= 1'b0;
            end else begin
              // Timed out with nobody waiting: owner keeps it, ptr untouched.
              hold_cnt    <= 8'd1;
            end
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;

endmodule
